lcd_timing_ctrl: RTL and testbench

LCD_TIMING_CTRL -- requirements
Module: lcd_timing_ctrl

---
 rtl/lcd_timing_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lcd_timing_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: RGB LCD panel timing generator.
//
// Generates hsync/vsync/data-enable for a parallel RGB panel, requests
// pixels one cycle ahead of the panel (pixel_x/pixel_y) and forwards the
// source's registered pixel_data to the panel while lcd_de is high.
// Frames are started by disp_on; dropping disp_on lets the current frame
// finish before the controller goes idle.
//
// Optional feature: define LCD_FRAME_CNT_EN to build the 16-bit frame
// counter; otherwise frame_cnt is tied to zero and no counter flops exist.
//
// Ports:
//   lcd_pclk    in   1   pixel clock, all state on its rising edge
//   rst_n       in   1   asynchronous active-low reset
//   disp_on     in   1   request to run frames
//   pixel_data  in  24   RGB888 from the source, one cycle after pixel_x/y
//   pixel_x     out 11   requested column (0 when no request)
//   pixel_y     out 11   requested row (0 when no request)
//   h_disp      out 11   constant H_DISP
//   v_disp      out 11   constant V_DISP
//   lcd_hs      out  1   hsync, active low
//   lcd_vs      out  1   vsync, active low
//   lcd_de      out  1   data enable
//   lcd_rgb     out 24   panel data, zero outside lcd_de
//   frame_done  out  1   one-cycle pulse on the last cycle of each frame
//   frame_cnt   out 16   completed-frame counter (0 without LCD_FRAME_CNT_EN)

module lcd_timing_ctrl #(
  parameter int unsigned H_SYNC  = 1,
  parameter int unsigned H_BACK  = 46,
  parameter int unsigned H_DISP  = 800,
  parameter int unsigned H_FRONT = 210,
  parameter int unsigned V_SYNC  = 1,
  parameter int unsigned V_BACK  = 23,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FRONT = 22
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic        disp_on,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [10:0] HTotM1    = 11'(H_TOTAL - 1);
  localparam logic [10:0] VTotM1    = 11'(V_TOTAL - 1);
  localparam logic [10:0] HSyncW    = 11'(H_SYNC);
  localparam logic [10:0] VSyncW    = 11'(V_SYNC);
  // Requests start one cycle before the active window so that the source's
  // registered pixel_data lines up with the registered lcd_de.
  localparam logic [10:0] HReqStart = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] HReqEnd   = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0] VActStart = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VActEnd   = 11'(V_SYNC + V_BACK + V_DISP);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic [10:0] w_h_cnt_d;
  logic [10:0] w_v_cnt_d;
  logic        r_de;

  logic w_active;
  logic w_h_end;
  logic w_v_end;
  logic w_frame_end;
  logic w_data_req;

  assign w_active    = (r_state != StIdle);
  assign w_h_end     = (r_h_cnt == HTotM1);
  assign w_v_end     = (r_v_cnt == VTotM1);
  assign w_frame_end = w_active & w_h_end & w_v_end;

  // Next-state logic. A RUN frame that sees disp_on low on its very last
  // cycle goes straight to IDLE rather than draining a whole extra frame.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (disp_on) w_state_d = StRun;
      end
      StRun: begin
        if (!disp_on) w_state_d = w_frame_end ? StIdle : StDrain;
      end
      StDrain: begin
        if (disp_on)          w_state_d = StRun;
        else if (w_frame_end) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Counters hold at zero in IDLE and free-run otherwise; toggling disp_on
  // only changes the state, never the counters.
  always_comb begin
    w_h_cnt_d = r_h_cnt;
    w_v_cnt_d = r_v_cnt;
    if (!w_active) begin
      w_h_cnt_d = '0;
      w_v_cnt_d = '0;
    end else if (w_h_end) begin
      w_h_cnt_d = '0;
      w_v_cnt_d = w_v_end ? 11'd0 : r_v_cnt + 11'd1;
    end else begin
      w_h_cnt_d = r_h_cnt + 11'd1;
    end
  end

  assign w_data_req = w_active &
                      (r_h_cnt >= HReqStart) & (r_h_cnt < HReqEnd) &
                      (r_v_cnt >= VActStart) & (r_v_cnt < VActEnd);

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_de    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_h_cnt <= w_h_cnt_d;
      r_v_cnt <= w_v_cnt_d;
      r_de    <= w_data_req;
    end
  end

  // Sync outputs are gated by state so IDLE (counters at 0) reads inactive.
  assign lcd_hs     = ~(w_active & (r_h_cnt < HSyncW));
  assign lcd_vs     = ~(w_active & (r_v_cnt < VSyncW));
  assign lcd_de     = r_de;
  assign lcd_rgb    = r_de ? pixel_data : 24'h000000;
  assign pixel_x    = w_data_req ? (r_h_cnt - HReqStart) : 11'd0;
  assign pixel_y    = w_data_req ? (r_v_cnt - VActStart) : 11'd0;
  assign frame_done = w_frame_end;
  assign h_disp     = 11'(H_DISP);
  assign v_disp     = 11'(V_DISP);

`ifdef LCD_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Directed bench for lcd_timing_ctrl with a small panel:
// H 2/3/8/2 (H_TOTAL=15), V 1/2/4/1 (V_TOTAL=8), 120 cycles per frame.
// Expected values per frame cycle c (h = c % 15, v = c / 15) are written
// from the timing numbers directly.

module tb_lcd_timing_ctrl;

  logic        clk;
  logic        rst_n;
  logic        disp_on;
  logic [23:0] pixel_data;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [23:0] lcd_rgb;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int          n_vec;
  int          n_err;
  logic [15:0] exp_fcnt;

  lcd_timing_ctrl #(
    .H_SYNC (2),
    .H_BACK (3),
    .H_DISP (8),
    .H_FRONT(2),
    .V_SYNC (1),
    .V_BACK (2),
    .V_DISP (4),
    .V_FRONT(1)
  ) dut (
    .lcd_pclk  (clk),
    .rst_n     (rst_n),
    .disp_on   (disp_on),
    .pixel_data(pixel_data),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .h_disp    (h_disp),
    .v_disp    (v_disp),
    .lcd_hs    (lcd_hs),
    .lcd_vs    (lcd_vs),
    .lcd_de    (lcd_de),
    .lcd_rgb   (lcd_rgb),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s @%0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  // Outputs that must read their idle/reset values.
  task automatic chk_idle(input string tag, input int c);
    chk({tag, "_hs"}, c, 32'(lcd_hs), 32'd1);
    chk({tag, "_vs"}, c, 32'(lcd_vs), 32'd1);
    chk({tag, "_de"}, c, 32'(lcd_de), 32'd0);
    chk({tag, "_rgb"}, c, 32'(lcd_rgb), 32'd0);
    chk({tag, "_px"}, c, 32'(pixel_x), 32'd0);
    chk({tag, "_py"}, c, 32'(pixel_y), 32'd0);
    chk({tag, "_fd"}, c, 32'(frame_done), 32'd0);
    chk({tag, "_fcnt"}, c, 32'(frame_cnt), 32'(exp_fcnt));
  endtask

  // Full check of one running frame cycle.
  task automatic check_cycle(input int c);
    int   h;
    int   v;
    logic req;
    logic de;
    h   = c % 15;
    v   = c / 15;
    req = (h >= 4) && (h <= 11) && (v >= 3) && (v <= 6);
    de  = (h >= 5) && (h <= 12) && (v >= 3) && (v <= 6);
    chk("hs", c, 32'(lcd_hs), (h >= 2) ? 32'd1 : 32'd0);
    chk("vs", c, 32'(lcd_vs), (v >= 1) ? 32'd1 : 32'd0);
    chk("de", c, 32'(lcd_de), 32'(de));
    chk("px", c, 32'(pixel_x), req ? 32'(h - 4) : 32'd0);
    chk("py", c, 32'(pixel_y), req ? 32'(v - 3) : 32'd0);
    chk("rgb", c, 32'(lcd_rgb), de ? 32'(pixel_data) : 32'd0);
    chk("fd", c, 32'(frame_done), (c == 119) ? 32'd1 : 32'd0);
    chk("fcnt", c, 32'(frame_cnt), 32'(exp_fcnt));
`ifdef LCD_FRAME_CNT_EN
    if (c == 119) exp_fcnt = exp_fcnt + 16'd1;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    exp_fcnt   = 16'h0000;
    rst_n      = 1'b0;
    disp_on    = 1'b0;
    pixel_data = 24'hFF0000;

    // Reset state, with pixel_data non-zero and disp_on low.
    repeat (3) tick();
    chk_idle("rst", 0);
    chk("h_disp", 0, 32'(h_disp), 32'd8);
    chk("v_disp", 0, 32'(v_disp), 32'd4);

    // Frame 1: start straight out of reset.
    rst_n   = 1'b1;
    disp_on = 1'b1;
    for (int c = 0; c < 120; c++) begin
      tick();
      check_cycle(c);
    end

    // Frame 2: different pixel value; disp_on dips 50..60 without effect.
    pixel_data = 24'h12A5C3;
    for (int c = 0; c < 120; c++) begin
      tick();
      check_cycle(c);
      if (c == 50) disp_on = 1'b0;
      if (c == 60) disp_on = 1'b1;
    end

    // Frame 3: disp_on drops at 50 and stays low; frame must still finish.
    pixel_data = 24'hFF0000;
    for (int c = 0; c < 120; c++) begin
      tick();
      check_cycle(c);
      if (c == 50) disp_on = 1'b0;
    end

    // Idle afterwards.
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_idle("idle", c);
    end
    chk("h_disp_idle", 0, 32'(h_disp), 32'd8);

    // Frame 4: restart, then asynchronous reset during active cycle 70.
    disp_on = 1'b1;
    for (int c = 0; c <= 70; c++) begin
      tick();
      check_cycle(c);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_fcnt = 16'h0000;
    chk_idle("rst_async", 70);
    chk("v_disp_rst", 70, 32'(v_disp), 32'd4);
    #2;
    rst_n = 1'b1;

    // Frame 5: restart from h=0,v=0 after reset.
    for (int c = 0; c < 120; c++) begin
      tick();
      check_cycle(c);
`ifdef LCD_FRAME_CNT_EN
      if (c == 20) begin
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        exp_fcnt = 16'hFFFF;
      end
`endif
    end

    // First cycle of frame 6: counter wrapped (or still 0 without the counter).
    tick();
    check_cycle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
